// File: rtl/uart_fifo_pkg.sv
// Shared FIFO constants, trigger-level encoding and helper for the UART FIFOs.
package uart_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DFLT = 8;
    localparam int unsigned FIFO_DEPTH_DFLT = 16;
    localparam int unsigned FIFO_ERR_W_DFLT = 3;

    // 16550 FCR[7:6] trigger-level encoding
    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_Q  = 2'b01,
        TRIG_H  = 2'b10,
        TRIG_NF = 2'b11
    } trig_sel_e;

    // Occupancy threshold for a given trigger select and FIFO depth
    function automatic int unsigned trig_level(input trig_sel_e sel, input int unsigned depth);
        case (sel)
            TRIG_1:  return 1;
            TRIG_Q:  return depth / 4;
            TRIG_H:  return depth / 2;
            default: return depth - 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x W array, synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned W     = 11,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised UART byte FIFO with error sideband, occupancy, flush and trigger level.
module uart_fifo_gen
    import uart_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = FIFO_WIDTH_DFLT,
    parameter  int unsigned DEPTH = FIFO_DEPTH_DFLT,
    parameter  int unsigned ERR_W = FIFO_ERR_W_DFLT,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] din,
    input  logic [ERR_W-1:0] err_in,
    input  logic [1:0]       trig_sel,
    output logic [WIDTH-1:0] dout,
    output logic [ERR_W-1:0] err_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overrun,
    output logic             underrun,
    output logic             thre_trigger,
    output logic             err_in_fifo
);

    localparam int unsigned AW = CNT_W - 1;

    logic [CNT_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       err_cnt;
    logic [WIDTH+ERR_W-1:0] rd_word;
    logic                   do_push;
    logic                   do_pop;
    logic                   err_inc;
    logic                   err_dec;
    logic                   ptr_msb_unused;

    // Occupancy is tracked by count, so the pointer MSBs only exist for wrap symmetry
    assign ptr_msb_unused = wr_ptr[CNT_W-1] ^ rd_ptr[CNT_W-1];

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (WIDTH + ERR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push & ~flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({din, err_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    // Transfer qualification, show-ahead head and status flags
    always_comb begin
        empty        = (count == '0);
        full         = (count == CNT_W'(DEPTH));
        do_pop       = en & pop_in & ~empty;
        do_push      = en & push_in & (~full | do_pop);
        dout         = empty ? '0 : rd_word[WIDTH+ERR_W-1:ERR_W];
        err_out      = empty ? '0 : rd_word[ERR_W-1:0];
        err_inc      = do_push & (|err_in);
        err_dec      = do_pop & (|err_out);
        thre_trigger = (count >= CNT_W'(trig_level(trig_sel_e'(trig_sel), DEPTH)));
        err_in_fifo  = (err_cnt != '0);
    end

    // Pointer, occupancy, error-count and pulse flag registers; flush overrides traffic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_cnt  <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_cnt  <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({err_inc, err_dec})
                2'b10:   err_cnt <= err_cnt + 1'b1;
                2'b01:   err_cnt <= err_cnt - 1'b1;
                default: err_cnt <= err_cnt;
            endcase
            overrun  <= en & push_in & full & ~do_pop;
            underrun <= en & pop_in & empty;
        end
    end

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed self-checking bench for uart_fifo_gen (16 x 8-bit, 3-bit sideband).
module tb_uart_fifo_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       flush = 1'b0;
    logic       push_in = 1'b0;
    logic       pop_in = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] err_in = '0;
    logic [1:0] trig_sel = 2'b00;
    logic [7:0] dout;
    logic [2:0] err_out;
    logic [4:0] count;
    logic       empty, full, overrun, underrun, thre_trigger, err_in_fifo;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    uart_fifo_gen #(
        .WIDTH (8),
        .DEPTH (16),
        .ERR_W (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .push_in      (push_in),
        .pop_in       (pop_in),
        .din          (din),
        .err_in       (err_in),
        .trig_sel     (trig_sel),
        .dout         (dout),
        .err_out      (err_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun),
        .underrun     (underrun),
        .thre_trigger (thre_trigger),
        .err_in_fifo  (err_in_fifo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock of traffic; outputs are stable 1 time unit after the edge
    task automatic drive(input logic p, input logic q, input logic [7:0] d,
                         input logic [2:0] e, input logic f);
        push_in = p; pop_in = q; din = d; err_in = e; flush = f;
        @(posedge clk);
        #1;
        push_in = 1'b0; pop_in = 1'b0; flush = 1'b0; err_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_dout", dout, 0);
        check("rst_flags", {full, overrun, underrun, thre_trigger, err_in_fifo}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Async reset in the middle of operation
        for (int i = 1; i <= 5; i++) drive(1, 0, 8'(i), (i == 2) ? 3'b001 : 3'b000, 0);
        check("pre_rst_count", count, 5);
        check("pre_rst_err", err_in_fifo, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_dout", dout, 0);
        check("async_rst_err", err_in_fifo, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fill, then push into a full FIFO
        for (int i = 1; i <= 16; i++) drive(1, 0, 8'(i), 3'b000, 0);
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        drive(1, 0, 8'h11, 3'b000, 0);
        check("ovr_pulse", overrun, 1);
        check("ovr_count", count, 16);
        check("ovr_dout", dout, 8'h01);
        drive(0, 0, 8'h00, 3'b000, 0);
        check("ovr_clear", overrun, 0);

        // Drain in order, then pop an empty FIFO
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), dout, i);
            drive(0, 1, 8'h00, 3'b000, 0);
        end
        check("drain_empty", empty, 1);
        drive(0, 1, 8'h00, 3'b000, 0);
        check("udr_pulse", underrun, 1);
        check("udr_count", count, 0);
        drive(0, 0, 8'h00, 3'b000, 0);
        check("udr_clear", underrun, 0);

        // Simultaneous push and pop while full
        for (int i = 1; i <= 16; i++) drive(1, 0, 8'(i), 3'b000, 0);
        drive(1, 1, 8'hAA, 3'b000, 0);
        check("pp_count", count, 16);
        check("pp_ovr", overrun, 0);
        check("pp_dout", dout, 8'h02);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("pp_tail", dout, 8'hAA);
            drive(0, 1, 8'h00, 3'b000, 0);
        end
        check("pp_empty", empty, 1);

        // Trigger levels
        trig_sel = 2'b11;
        for (int i = 0; i < 13; i++) drive(1, 0, 8'(i), 3'b000, 0);
        check("trig_nf_13", thre_trigger, 0);
        drive(1, 0, 8'h20, 3'b000, 0);
        check("trig_nf_14", thre_trigger, 1);
        drive(0, 0, 8'h00, 3'b000, 1);
        trig_sel = 2'b00;
        #1;
        check("trig_1_cnt0", thre_trigger, 0);
        drive(1, 0, 8'h21, 3'b000, 0);
        check("trig_1_cnt1", thre_trigger, 1);
        trig_sel = 2'b01;
        #1;
        check("trig_q_cnt1", thre_trigger, 0);
        trig_sel = 2'b00;
        drive(0, 0, 8'h00, 3'b000, 1);

        // Global enable low: traffic ignored, no pulses
        en = 1'b0;
        drive(1, 0, 8'h77, 3'b000, 0);
        check("en0_count", count, 0);
        drive(0, 1, 8'h00, 3'b000, 0);
        check("en0_udr", underrun, 0);
        en = 1'b1;

        // Error sideband tracking and flush priority
        drive(1, 0, 8'h10, 3'b000, 0);
        drive(1, 0, 8'h11, 3'b000, 0);
        check("err_before", err_in_fifo, 0);
        drive(1, 0, 8'h55, 3'b010, 0);
        drive(1, 0, 8'h12, 3'b000, 0);
        check("err_set", err_in_fifo, 1);
        drive(0, 1, 8'h00, 3'b000, 0);
        drive(0, 1, 8'h00, 3'b000, 0);
        check("err_head_dout", dout, 8'h55);
        check("err_head_side", err_out, 3'b010);
        check("err_held", err_in_fifo, 1);
        drive(0, 1, 8'h00, 3'b000, 0);
        check("err_popped", err_in_fifo, 0);
        check("err_next_dout", dout, 8'h12);
        drive(1, 0, 8'h66, 3'b001, 0);
        check("err_again", err_in_fifo, 1);
        drive(1, 0, 8'h67, 3'b100, 1);
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_err", err_in_fifo, 0);
        check("flush_dout", dout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
